// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. It issues word-aligned read requests to the
//   instruction memory, pairs each returned word with the PC it was fetched
//   from, and presents the result to decode through a small instruction FIFO.
//   When a redirect arrives, the FIFO is flushed and responses that are still
//   in flight are discarded.
//
//   Build option:
//     FETCH_BYPASS_EN - when this is defined, a response that arrives while the
//                       FIFO is empty is shown on inst_* in the same cycle.
//                       If decode takes it that cycle, it is never written
//                       into the FIFO.
//
// Parameters
//   ResetPc  first fetch address after reset
//   Depth    instruction buffer entries (power of two, >= 2)
//
// Ports
//   clk_i, rst_i          clock and synchronous active-high reset
//   instmem_*             read-request / response interface to instruction memory
//   redirect_i/_pc_i      flush and restart fetch at a new address
//   inst_valid_o/ready_i  valid/ready handshake towards decode
//   inst_pc_o/data_o      PC and word of the presented instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] ResetPc = 32'h0000_0000,
  parameter int unsigned Depth   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instmem_ready_i,
  output logic        instmem_valid_o,
  output logic [31:0] instmem_addr_o,
  output logic [31:0] instmem_wdata_o,
  output logic [3:0]  instmem_wmask_o,
  input  logic [31:0] instmem_rdata_i,
  input  logic        instmem_rvalid_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_pc_o,
  output logic [31:0] inst_data_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [CntW+1:0] sum_t;

  logic [31:0] fetch_pc;

  // PCs of live requests. Requests that were cancelled by a redirect are not
  // kept here. They are tracked only by disc_cnt.
  logic [31:0] infl_pc [Depth];
  ptr_t        infl_wr, infl_rd;
  cnt_t        infl_cnt;
  cnt_t        disc_cnt;

  logic [31:0] fifo_pc   [Depth];
  logic [31:0] fifo_data [Depth];
  ptr_t        fifo_wr, fifo_rd;
  cnt_t        fifo_cnt;

  sum_t        occupancy;
  logic        issue;
  logic        resp_any;
  logic        resp_drop;
  logic        resp_keep;
  logic [31:0] resp_pc;
  logic        fifo_empty;
  logic        bypass;
  logic        consume;
  logic        pop;
  logic        push;
  logic        unused_bits;

  assign unused_bits = ^redirect_pc_i[1:0];

  // Every outstanding request (live or discarded) holds one buffer slot.
  // A response can therefore always be written into the FIFO.
  assign occupancy       = sum_t'(infl_cnt) + sum_t'(disc_cnt) + sum_t'(fifo_cnt);
  assign instmem_valid_o = !rst_i && (occupancy < sum_t'(Depth));
  assign instmem_addr_o  = fetch_pc;
  assign instmem_wdata_o = 32'h0;
  assign instmem_wmask_o = 4'h0;
  assign issue           = instmem_valid_o && instmem_ready_i;

  // A response when nothing is outstanding is treated as stale and ignored.
  assign resp_any  = instmem_rvalid_i && ((infl_cnt != '0) || (disc_cnt != '0));
  assign resp_drop = instmem_rvalid_i && (disc_cnt != '0);
  assign resp_keep = instmem_rvalid_i && (disc_cnt == '0) && (infl_cnt != '0);
  assign resp_pc   = infl_pc[infl_rd];

  assign fifo_empty = (fifo_cnt == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_keep && fifo_empty && !redirect_i;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid_o = !fifo_empty || bypass;
  assign inst_pc_o    = fifo_empty ? resp_pc         : fifo_pc[fifo_rd];
  assign inst_data_o  = fifo_empty ? instmem_rdata_i : fifo_data[fifo_rd];

  // A redirect flushes everything, so decode's ready is ignored in that cycle.
  assign consume = inst_valid_o && inst_ready_i && !redirect_i;
  assign pop     = consume && !fifo_empty;
  assign push    = resp_keep && !(bypass && consume);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= {ResetPc[31:2], 2'b00};
      infl_wr  <= '0;
      infl_rd  <= '0;
      infl_cnt <= '0;
      disc_cnt <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      infl_wr  <= '0;
      infl_rd  <= '0;
      infl_cnt <= '0;
      // Everything still outstanding after this edge belongs to the old path.
      disc_cnt <= disc_cnt + infl_cnt + cnt_t'(issue) - cnt_t'(resp_any);
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        infl_wr  <= infl_wr + ptr_t'(1);
      end
      if (resp_keep) begin
        infl_rd <= infl_rd + ptr_t'(1);
      end
      infl_cnt <= infl_cnt + cnt_t'(issue) - cnt_t'(resp_keep);
      if (resp_drop) begin
        disc_cnt <= disc_cnt - cnt_t'(1);
      end
      if (push) begin
        fifo_wr <= fifo_wr + ptr_t'(1);
      end
      if (pop) begin
        fifo_rd <= fifo_rd + ptr_t'(1);
      end
      fifo_cnt <= fifo_cnt + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Storage arrays need no reset. Their contents are only read through the
  // counters, which are reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !redirect_i && issue) begin
      infl_pc[infl_wr] <= fetch_pc;
    end
    if (!rst_i && !redirect_i && push) begin
      fifo_pc[fifo_wr]   <= resp_pc;
      fifo_data[fifo_wr] <= instmem_rdata_i;
    end
  end

endmodule
